// File: rtl/clock_crossing_pkg.sv
// Shared types for the toggle-handshake pulse crossing (tx and rx halves).
package clock_crossing_pkg;

    typedef enum logic {
        HS_IDLE     = 1'b0,
        HS_WAIT_ACK = 1'b1
    } hs_state_t;

endpackage : clock_crossing_pkg

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter; sat_drop flags an increment lost at the maximum value.
module sat_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             sat_drop
);

    localparam logic [WIDTH-1:0] MAX_VALUE = '1;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] value_next;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        value_next = value;
        sat_drop   = 1'b0;
        if (inc && !dec) begin
            if (value == MAX_VALUE) begin
                sat_drop = 1'b1;
            end else begin
                value_next = value + ONE;
            end
        end else if (dec && !inc && value != '0) begin
            value_next = value - ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

endmodule : sat_updown_counter

// File: rtl/pulse_handshake_tx.sv
// Source half of a toggle-handshake pulse crossing: counts events, launches one toggle per ack.
// Optional ack-wait timeout flag is compiled in with PULSE_HANDSHAKE_TX_TIMEOUT_EN.
module pulse_handshake_tx
    import clock_crossing_pkg::*;
#(
    parameter int COUNT_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   evt_in,
    output logic                   req_toggle,
    input  logic                   ack_toggle_sync,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] pending,
    output logic                   overflow,
    input  logic                   clr_err
`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    hs_state_t state;
    hs_state_t state_next;
    logic      launch;
    logic      sat_drop;

    sat_updown_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_pending_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (evt_in),
        .dec     (launch),
        .value   (pending),
        .sat_drop(sat_drop)
    );

    // An event arriving in IDLE with nothing queued launches immediately and never touches the counter.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            HS_IDLE: begin
                if (pending != '0 || evt_in) begin
                    launch     = 1'b1;
                    state_next = HS_WAIT_ACK;
                end
            end
            HS_WAIT_ACK: begin
                if (ack_toggle_sync == req_toggle) begin
                    state_next = HS_IDLE;
                end
            end
            default: state_next = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HS_IDLE;
            req_toggle <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == HS_WAIT_ACK);
            if (launch) begin
                req_toggle <= ~req_toggle;
            end
            if (sat_drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_cnt;

    // Counter parks at its last value; the FSM keeps waiting, only the flag reports the stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (launch) begin
                wait_cnt <= '0;
            end else if (state == HS_WAIT_ACK && wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + WAIT_ONE;
            end
            if (state == HS_WAIT_ACK && wait_cnt == WAIT_LAST) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end
`endif

endmodule : pulse_handshake_tx

// File: tb/tb_pulse_handshake_tx.sv
// Self-checking bench for pulse_handshake_tx: vector table, toggle scoreboard, corner-case sequences.
// Timeout checks are compiled in with PULSE_HANDSHAKE_TX_TIMEOUT_EN.
module tb_pulse_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       evt_in;
    logic       ack_toggle_sync;
    logic       clr_err;
    logic       req_toggle;
    logic       busy;
    logic [3:0] pending;
    logic       overflow;

    logic       evt2;
    logic       ack2;
    logic       clr2;
    logic       req2;
    logic       busy2;
    logic [1:0] pend2;
    logic       ovf2;

`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
    logic       tmo;
    logic       tmo2;
`endif

    always #5 clk = ~clk;

    pulse_handshake_tx #(.COUNT_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .evt_in         (evt_in),
        .req_toggle     (req_toggle),
        .ack_toggle_sync(ack_toggle_sync),
        .busy           (busy),
        .pending        (pending),
        .overflow       (overflow),
        .clr_err        (clr_err)
`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
        ,
        .timeout_err    (tmo)
`endif
    );

    pulse_handshake_tx #(.COUNT_WIDTH(2), .TIMEOUT_CYCLES(16)) dut_w2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .evt_in         (evt2),
        .req_toggle     (req2),
        .ack_toggle_sync(ack2),
        .busy           (busy2),
        .pending        (pend2),
        .overflow       (ovf2),
        .clr_err        (clr2)
`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
        ,
        .timeout_err    (tmo2)
`endif
    );

    typedef struct {
        logic       evt;
        logic       req;
        logic       busy;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[16];
    logic exp_q[$];
    logic last_push;
    logic prev_req;
    logic [3:0] hist;
    logic loop_en;
    int   n_cmp;
    int   n_fail;
    int   n_toggles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: outputs are observed 1 time unit after the edge, then the ack loopback advances.
    task automatic tick();
        logic exp_level;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            prev_req  = 1'b0;
            last_push = 1'b0;
            hist      = '0;
            ack_toggle_sync = 1'b0;
        end else begin
            if (req_toggle !== prev_req) begin
                n_toggles++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_toggle: req_toggle=%0d with no queued event (t=%0t)", req_toggle, $time);
                end else begin
                    exp_level = exp_q.pop_front();
                    check("toggle_level", req_toggle, exp_level);
                end
                prev_req = req_toggle;
            end
            if (loop_en) begin
                hist = {hist[2:0], req_toggle};
                ack_toggle_sync = hist[3];
            end
        end
    endtask

    task automatic step(input logic evt_v);
        evt_in = evt_v;
        if (evt_v && rst_n) begin
            last_push = ~last_push;
            exp_q.push_back(last_push);
        end
        tick();
        evt_in = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((busy || pending != 0) && n < max_cycles) begin
            step(1'b0);
            n++;
        end
        check("idle_within_budget", {31'd0, (busy || pending != 0)}, 0);
        repeat (4) step(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; n_toggles = 0;
        rst_n = 1'b0; evt_in = 1'b0; clr_err = 1'b0; ack_toggle_sync = 1'b0;
        evt2 = 1'b0; ack2 = 1'b0; clr2 = 1'b0;
        loop_en = 1'b1; hist = '0; prev_req = 1'b0; last_push = 1'b0;

        // single event, ack looped back with 3-cycle delay
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0};
        // five back-to-back events: pending climbs to 4 while the first waits for ack
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'd3};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd4};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'd3};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'd3};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 4'd3};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 4'd3};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 4'd3};

        tick();
        tick();
        check("rst_req", req_toggle, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_overflow", overflow, 0);
        check("rst_w2_pending", pend2, 0);
`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
        check("rst_timeout", tmo, 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].evt);
            check($sformatf("vec%0d_req", i), req_toggle, vecs[i].req);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_pending", i), pending, vecs[i].pend);
            check($sformatf("vec%0d_overflow", i), overflow, 0);
        end
        wait_idle(40);
        check("sb_drained", exp_q.size(), 0);
        check("toggles_total", n_toggles, 6);

        // event on the same edge the ack matches: counted, launched on the next edge
        step(1'b1);
        check("match_launch_req", req_toggle, 1);
        repeat (3) step(1'b0);
        check("match_still_busy", busy, 1);
        step(1'b1);
        check("match_busy", busy, 0);
        check("match_pending", pending, 1);
        step(1'b0);
        check("match_relaunch_busy", busy, 1);
        check("match_relaunch_pending", pending, 0);
        check("match_relaunch_req", req_toggle, 0);
        wait_idle(20);
        check("sb_drained2", exp_q.size(), 0);

        // reset in the middle of WAIT_ACK with two events queued
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("pre_rst_pending", pending, 2);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_req", req_toggle, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (6) step(1'b0);
        check("post_rst_req", req_toggle, 0);
        check("post_rst_pending", pending, 0);
        check("post_rst_busy", busy, 0);

        // COUNT_WIDTH=2 instance, ack held low: saturation and overflow stickiness
        evt2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("w2_pend%0d", i), pend2, (i == 0) ? 0 : ((i > 3) ? 3 : i));
            check($sformatf("w2_ovf%0d", i), ovf2, (i == 4) ? 1 : 0);
        end
        check("w2_busy", busy2, 1);
        check("w2_req", req2, 1);
        clr2 = 1'b1;
        tick();
        check("w2_set_wins", ovf2, 1);
        check("w2_pend_held", pend2, 3);
        evt2 = 1'b0;
        tick();
        check("w2_cleared", ovf2, 0);
        clr2 = 1'b0;

`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
        // ack never returns: flag after 16 WAIT_ACK cycles, FSM keeps waiting
        loop_en = 1'b0;
        step(1'b1);
        repeat (15) step(1'b0);
        check("tmo_not_yet", tmo, 0);
        step(1'b0);
        check("tmo_set", tmo, 1);
        check("tmo_still_busy", busy, 1);
        ack_toggle_sync = req_toggle;
        step(1'b0);
        check("tmo_late_ack_idle", busy, 0);
        check("tmo_sticky", tmo, 1);
        clr_err = 1'b1;
        step(1'b0);
        clr_err = 1'b0;
        check("tmo_cleared", tmo, 0);
        hist = {4{req_toggle}};
        loop_en = 1'b1;
`endif

        check("final_overflow", overflow, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pulse_handshake_tx
